uart_encoder: RTL and testbench
===============================

UART_ENCODER -- requirements
Module: uart_encoder

Interface
REQ-001 The block SHALL have parameter REFRESH_CYCLES, default 1_000_000, meaning idle cycles after which a frame is re-sent unchanged (0 disables refresh).
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 player_id  input  2  local player number (2'b01 = player 1, 2'b10 = player 2).
REQ-005 pos_x  input  8  local player x position.
REQ-006 pos_y  input  8  local player y position.
REQ-007 collision  input  1  local player collision flag.
REQ-008 send  input  1  single-cycle request to transmit a frame.
REQ-009 tx_full  input  1  TX FIFO full flag.
REQ-010 w_data  output  8  byte to the TX FIFO, valid when wr_uart=1.
REQ-011 wr_uart  output  1  one-cycle TX FIFO write strobe.
REQ-012 busy  output  1  high while a frame is in progress.
REQ-013 frame_done  output  1  one-cycle pulse after the last byte of a frame is written.

Function
REQ-014 Byte format SHALL be bits[2:0] = opcode, bit[3] = 0, bits[7:4] = payload.
REQ-015 A frame SHALL be six bytes in this order: SEL {2'b00, player_id, 1'b0, 3'b000}; XL {x[3:0],0,3'b001}; XH {x[7:4],0,3'b010}; YH {y[7:4],0,3'b011}; YL {y[3:0],0,3'b100}; COL {3'b000, collision, 0, 3'b101}.
REQ-016 FSM states SHALL be IDLE, SEL, XL, XH, YH, YL, COL, WAIT; busy=1 in every state except IDLE.
REQ-017 In IDLE, a frame SHALL start on: send=1; {player_id,pos_x,pos_y,collision} differing from the last-sent registers; or refresh counter reaching REFRESH_CYCLES-1 (REFRESH_CYCLES>0).
REQ-018 On frame start, player_id, pos_x, pos_y and collision SHALL be captured into a snapshot; all six bytes SHALL come from the snapshot, so input changes mid-frame do not affect the current frame.
REQ-019 In each byte state with tx_full=0, the block SHALL, in the next cycle, assert wr_uart=1 with that byte on w_data and enter WAIT.
REQ-020 In a byte state with tx_full=1, the block SHALL hold state with wr_uart=0 indefinitely.
REQ-021 WAIT SHALL last exactly one cycle with wr_uart=0, then go to the next byte state, so consecutive writes are at least 2 cycles apart.
REQ-022 wr_uart and w_data SHALL be registered outputs; w_data SHALL hold its last value while wr_uart=0.
REQ-023 After the COL write and its WAIT cycle, the block SHALL pulse frame_done for one cycle, copy the snapshot into the last-sent registers, and return to IDLE.
REQ-024 send asserted while busy=1 SHALL be ignored and not queued; input changes during a frame SHALL trigger a new frame via change-detect once back in IDLE.
REQ-025 The refresh counter SHALL increment only in IDLE, and clear on every frame start and at reset.
REQ-026 Simultaneous trigger conditions SHALL start exactly one frame.

Reset
REQ-027 While rst=0: state=IDLE; w_data=8'h00; wr_uart=0; busy=0; frame_done=0; snapshot, last-sent registers and refresh counter cleared.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; no further wr_uart pulses SHALL occur for that frame.
REQ-029 After rst deasserts, nonzero inputs SHALL trigger a frame through change-detect (last-sent = 0).

Verification
REQ-030 player_id=01, pos_x=8'hA5, pos_y=8'h3C, collision=1, tx_full=0, send pulse -> wr_uart bytes 8'h10, 8'h51, 8'hA2, 8'h33, 8'hC4, 8'h15 on every other cycle, then one frame_done pulse.
REQ-031 tx_full held 1 for 10 cycles during XH -> no wr_uart while full; 8'hA2 written once after tx_full falls; no byte lost or duplicated.
REQ-032 pos_x changed 8'hA5->8'h00 during YH -> current frame finishes with 8'hA5 bytes; a second frame starts automatically carrying XL=8'h01, XH=8'h02.
REQ-033 REFRESH_CYCLES=16, inputs static after one frame -> next identical frame starts 16 cycles after returning to IDLE.
REQ-034 rst=0 after the second byte of a frame -> wr_uart stays 0, all outputs 0; after release with inputs all zero and no send, no frame is sent until refresh expiry.
REQ-035 send pulsed while busy=1 with unchanged inputs -> exactly one frame transmitted.

Source files
------------

// File: rtl/uart_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_encoder_if
// Description : Byte write bus between the UART frame encoder and the TX FIFO.
//               master : encoder side (drives w_data / wr_uart, sees tx_full)
//               slave  : FIFO side    (accepts w_data / wr_uart, drives tx_full)
//   w_data   [7:0]  byte to write, meaningful when wr_uart = 1
//   wr_uart         one-cycle write strobe
//   tx_full         FIFO full, writer must stall while high
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_encoder_if;
    logic [7:0] w_data;
    logic       wr_uart;
    logic       tx_full;

    modport master (output w_data, output wr_uart, input tx_full);
    modport slave  (input w_data, input wr_uart, output tx_full);
endinterface
`default_nettype wire

// File: rtl/uart_encoder.sv
`default_nettype none
// ============================================================================
// Module      : uart_encoder
// Description : Serialises the local player state into a six-byte frame and
//               writes it to a UART TX FIFO. A frame starts on an explicit
//               send request, on any change of the player state since the
//               last frame, or after REFRESH_CYCLES idle cycles (0 = never).
// Ports       :
//   clk                 system clock, rising edge
//   rst                 asynchronous reset, active low
//   player_id [1:0]     local player number
//   pos_x     [7:0]     local x position
//   pos_y     [7:0]     local y position
//   collision           local collision flag
//   send                single-cycle transmit request
//   tx (master)         TX FIFO write bus (w_data, wr_uart, tx_full)
//   busy                high while a frame is in progress
//   frame_done          one-cycle pulse once the last byte has been written
// Revision    : 1.0 - initial release
// ============================================================================
module uart_encoder #(
    parameter int REFRESH_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           player_id,
    input  logic [7:0]           pos_x,
    input  logic [7:0]           pos_y,
    input  logic                 collision,
    input  logic                 send,
    uart_encoder_if.master       tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int c_CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam bit c_REFRESH_EN = (REFRESH_CYCLES > 0);
    localparam logic [c_CNT_W-1:0] c_REFRESH_MAX =
        c_CNT_W'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEL  = 3'd1,
        S_XL   = 3'd2,
        S_XH   = 3'd3,
        S_YH   = 3'd4,
        S_YL   = 3'd5,
        S_COL  = 3'd6,
        S_WAIT = 3'd7
    } state_t;

    // Packed player state: {player_id, pos_x, pos_y, collision}
    state_t                r_state;
    state_t                r_after;      // state to enter when WAIT ends
    logic [18:0]           r_snap;
    logic [18:0]           r_last;
    logic [c_CNT_W-1:0]    r_refresh;
    logic [7:0]            r_data;
    logic                  r_wr;
    logic                  r_done;

    logic [18:0]           w_cur;
    logic                  w_start;
    logic [1:0]            w_pid;
    logic [7:0]            w_x;
    logic [7:0]            w_y;
    logic                  w_col;

    state_t                w_next;
    state_t                w_after;
    state_t                w_succ;
    logic                  w_is_byte;
    logic                  w_load;
    logic                  w_done;
    logic [7:0]            w_byte;

    assign w_cur = {player_id, pos_x, pos_y, collision};
    assign w_pid = r_snap[18:17];
    assign w_x   = r_snap[16:9];
    assign w_y   = r_snap[8:1];
    assign w_col = r_snap[0];

    // Any of the three triggers starts a single frame; they are simply OR-ed.
    assign w_start = send || (w_cur != r_last) ||
                     (c_REFRESH_EN && (r_refresh == c_REFRESH_MAX));

    always_comb begin
        w_next    = r_state;
        w_after   = r_after;
        w_succ    = S_IDLE;
        w_is_byte = 1'b0;
        w_load    = 1'b0;
        w_done    = 1'b0;
        w_byte    = 8'h00;
        case (r_state)
            S_IDLE: if (w_start) w_next = S_SEL;
            S_SEL: begin
                w_is_byte = 1'b1;
                w_byte    = {2'b00, w_pid, 1'b0, 3'b000};
                w_succ    = S_XL;
            end
            S_XL: begin
                w_is_byte = 1'b1;
                w_byte    = {w_x[3:0], 1'b0, 3'b001};
                w_succ    = S_XH;
            end
            S_XH: begin
                w_is_byte = 1'b1;
                w_byte    = {w_x[7:4], 1'b0, 3'b010};
                w_succ    = S_YH;
            end
            S_YH: begin
                w_is_byte = 1'b1;
                w_byte    = {w_y[7:4], 1'b0, 3'b011};
                w_succ    = S_YL;
            end
            S_YL: begin
                w_is_byte = 1'b1;
                w_byte    = {w_y[3:0], 1'b0, 3'b100};
                w_succ    = S_COL;
            end
            S_COL: begin
                w_is_byte = 1'b1;
                w_byte    = {3'b000, w_col, 1'b0, 3'b101};
                w_succ    = S_IDLE;
            end
            S_WAIT: begin
                w_next = r_after;
                w_done = (r_after == S_IDLE);
            end
            default: w_next = S_IDLE;
        endcase
        // A byte state stalls in place while the FIFO is full.
        if (w_is_byte && !tx.tx_full) begin
            w_load  = 1'b1;
            w_next  = S_WAIT;
            w_after = w_succ;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_after   <= S_IDLE;
            r_snap    <= '0;
            r_last    <= '0;
            r_refresh <= '0;
            r_data    <= 8'h00;
            r_wr      <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_after <= w_after;
            r_wr    <= w_load;
            r_done  <= w_done;
            if (w_load) begin
                r_data <= w_byte;
            end
            if (w_done) begin
                r_last <= r_snap;
            end
            if (r_state == S_IDLE) begin
                if (w_start) begin
                    r_snap    <= w_cur;
                    r_refresh <= '0;
                end else begin
                    r_refresh <= r_refresh + 1'b1;
                end
            end
        end
    end

    assign tx.w_data  = r_data;
    assign tx.wr_uart = r_wr;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_encoder
// Description : Scoreboard bench for uart_encoder (REFRESH_CYCLES = 16).
//               Stimulus pushes hand-computed frame bytes into a queue; a
//               monitor pops and compares on every FIFO write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] player_id = 2'b00;
    logic [7:0] pos_x = 8'h00;
    logic [7:0] pos_y = 8'h00;
    logic       collision = 1'b0;
    logic       send = 1'b0;
    logic       busy;
    logic       frame_done;

    uart_encoder_if tx_if();

    uart_encoder #(.REFRESH_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .player_id  (player_id),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .collision  (collision),
        .send       (send),
        .tx         (tx_if),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          wr_count = 0;
    int          fd_count = 0;
    int          last_wr_cyc = -100;
    int          first_wr_cyc = 0;
    int          fd_cyc = 0;
    logic        prev_fd = 1'b0;
    logic [7:0]  exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on every write strobe, frame_done bookkeeping.
    always @(negedge clk) begin
        if (tx_if.wr_uart) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {24'h0, tx_if.w_data}, 32'hFFFF_FFFF);
            end else begin
                check("frame_byte", {24'h0, tx_if.w_data}, {24'h0, exp_q.pop_front()});
            end
            check("write_gap_ge_2", ((cyc - last_wr_cyc) >= 2) ? 32'd1 : 32'd0, 32'd1);
            if (wr_count % 6 == 1) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
        end
        if (frame_done) begin
            fd_count++;
            fd_cyc = cyc;
            check("done_after_last_write", cyc - last_wr_cyc, 32'd1);
            check("done_single_cycle", {31'h0, prev_fd}, 32'd0);
        end
        prev_fd = frame_done;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push6(input logic [7:0] b0, b1, b2, b3, b4, b5);
        exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
        exp_q.push_back(b3); exp_q.push_back(b4); exp_q.push_back(b5);
    endtask

    task automatic wait_wr(input int n, input int budget, input string name);
        int k = 0;
        while (wr_count < n && k < budget) begin tick(); k++; end
        if (wr_count < n) check(name, wr_count, n);
    endtask

    task automatic wait_fd(input int n, input int budget, input string name);
        int k = 0;
        while (fd_count < n && k < budget) begin tick(); k++; end
        if (fd_count < n) check(name, fd_count, n);
    endtask

    task automatic pulse_send();
        send = 1'b1;
        tick();
        send = 1'b0;
    endtask

    initial begin
        int t0;
        int seen_busy;
        int k;
        tx_if.tx_full = 1'b0;

        // Reset state
        repeat (3) tick();
        check("reset_w_data", {24'h0, tx_if.w_data}, 32'h00);
        check("reset_wr_uart", {31'h0, tx_if.wr_uart}, 32'd0);
        check("reset_busy", {31'h0, busy}, 32'd0);
        check("reset_frame_done", {31'h0, frame_done}, 32'd0);

        // Basic frame, plus a send while busy that must be ignored
        rst = 1'b1;
        player_id = 2'b01; pos_x = 8'hA5; pos_y = 8'h3C; collision = 1'b1;
        push6(8'h10, 8'h51, 8'hA2, 8'h33, 8'hC4, 8'h15);
        pulse_send();
        wait_wr(1, 20, "t1_first_write_timeout");
        check("t1_busy_during_frame", {31'h0, busy}, 32'd1);
        pulse_send();
        wait_fd(1, 40, "t1_done_timeout");
        check("t1_frame_span", fd_cyc - first_wr_cyc, 32'd11);
        repeat (5) tick();
        check("t1_one_frame_only", wr_count, 32'd6);

        // FIFO full held for 10 cycles in XH
        push6(8'h10, 8'h51, 8'hA2, 8'h33, 8'hC4, 8'h15);
        pulse_send();
        wait_wr(8, 30, "t2_xl_timeout");
        tx_if.tx_full = 1'b1;
        repeat (10) tick();
        check("t2_no_write_while_full", wr_count, 32'd8);
        check("t2_busy_while_full", {31'h0, busy}, 32'd1);
        tx_if.tx_full = 1'b0;
        wait_fd(2, 40, "t2_done_timeout");
        check("t2_byte_count", wr_count, 32'd12);

        // Input change mid-frame: finish from snapshot, then change-detect frame
        push6(8'h10, 8'h51, 8'hA2, 8'h33, 8'hC4, 8'h15);
        push6(8'h10, 8'h01, 8'h02, 8'h33, 8'hC4, 8'h15);
        pulse_send();
        wait_wr(16, 40, "t3_yh_timeout");
        pos_x = 8'h00;
        wait_fd(4, 80, "t3_done_timeout");
        check("t3_byte_count", wr_count, 32'd24);

        // Refresh after 16 idle cycles with static inputs
        push6(8'h10, 8'h01, 8'h02, 8'h33, 8'hC4, 8'h15);
        t0 = fd_cyc;
        k = 0;
        while (!busy && k < 40) begin tick(); k++; end
        check("t4_refresh_delay", cyc - t0, 32'd16);
        wait_fd(5, 40, "t4_done_timeout");

        // Reset after second byte aborts the frame
        player_id = 2'b10; pos_x = 8'h12; pos_y = 8'h34; collision = 1'b0;
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h21);
        pulse_send();
        wait_wr(32, 30, "t5_xl_timeout");
        rst = 1'b0;
        player_id = 2'b00; pos_x = 8'h00; pos_y = 8'h00;
        tick();
        check("t5_rst_wr_uart", {31'h0, tx_if.wr_uart}, 32'd0);
        check("t5_rst_w_data", {24'h0, tx_if.w_data}, 32'h00);
        check("t5_rst_busy", {31'h0, busy}, 32'd0);
        check("t5_rst_frame_done", {31'h0, frame_done}, 32'd0);
        repeat (4) tick();
        rst = 1'b1;
        seen_busy = 0;
        repeat (14) begin tick(); if (busy) seen_busy = 1; end
        check("t5_quiet_after_release", seen_busy, 32'd0);
        check("t5_aborted_bytes", wr_count, 32'd32);
        push6(8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
        wait_fd(6, 40, "t5_refresh_done_timeout");
        check("t5_byte_count", wr_count, 32'd38);

        // Change-detect start without send
        player_id = 2'b01; pos_x = 8'h5A;
        push6(8'h10, 8'hA1, 8'h52, 8'h03, 8'h04, 8'h05);
        wait_fd(7, 40, "t6_done_timeout");
        check("t6_byte_count", wr_count, 32'd44);
        repeat (3) tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
